// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - oversampled UART transmitter with optional parity and 1/2 stop bits
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 ser_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_cnt;
  logic                 bit_end;

  assign bit_end  = baud_tick && (tick_cnt == CW'(OVERSAMPLE - 1));
  assign tx_ready = (state == IDLE) && !rst;
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      ser_out  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid) begin
          // Parity is taken from the byte as accepted, since the shift register is consumed
          shift    <= tx_data;
          par_bit  <= (^tx_data) ^ PARITY_ODD[0];
          tick_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          ser_out  <= 1'b0;
          state    <= START;
        end
      end else if (baud_tick) begin
        if (!bit_end) begin
          tick_cnt <= tick_cnt + CW'(1);
        end else begin
          tick_cnt <= '0;
          case (state)
            START: begin
              state   <= DATA;
              ser_out <= shift[0];
            end
            DATA: begin
              if (bit_cnt == 3'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                if (PARITY_EN != 0) begin
                  state   <= PARITY;
                  ser_out <= par_bit;
                end else begin
                  state   <= STOP;
                  ser_out <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= shift >> 1;
                ser_out <= shift[1];
              end
            end
            PARITY: begin
              state   <= STOP;
              ser_out <= 1'b1;
            end
            STOP: begin
              if (stop_cnt == 1'(STOP_BITS - 1)) begin
                state    <= IDLE;
                stop_cnt <= 1'b0;
                tx_done  <= 1'b1;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
            default: begin
              state   <= IDLE;
              ser_out <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized frame-level checking of uart_tx against a bit-list model
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] valid_v = 4'h0;
  wire  [3:0] ready_v, ser_v, busy_v, done_v;

  int n_total = 0;
  int n_pass  = 0;

  // Per-instance frame format used by the model
  int db_t[4] = '{8, 8, 8, 5};
  int os_t[4] = '{16, 16, 16, 4};
  int pe_t[4] = '{0, 1, 1, 0};
  int po_t[4] = '{0, 0, 1, 0};
  int sb_t[4] = '{1, 1, 1, 2};

  int exp_bits[$];

  int tick_per = 4;
  int tick_ph  = 0;
  bit tick_en  = 1'b1;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_ph   = (tick_ph + 1) % tick_per;
    baud_tick = tick_en && (tick_ph == 0);
  end

  uart_tx u_d0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .ser_out(ser_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx #(.PARITY_EN(1)) u_d1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .ser_out(ser_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .ser_out(ser_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  uart_tx #(.DATA_BITS(5), .OVERSAMPLE(4), .STOP_BITS(2)) u_d3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data[4:0]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .ser_out(ser_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Line levels of one frame, one entry per bit period
  function automatic void build(input int k, input logic [7:0] d);
    int ones;
    ones = 0;
    exp_bits = {};
    exp_bits.push_back(0);
    for (int i = 0; i < db_t[k]; i++) begin
      exp_bits.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (pe_t[k] != 0) exp_bits.push_back((ones % 2) ^ po_t[k]);
    for (int i = 0; i < sb_t[k]; i++) exp_bits.push_back(1);
  endfunction

  task automatic accept(input int k, input logic [7:0] d);
    @(negedge clk);
    tx_data    = d;
    valid_v[k] = 1'b1;
    check("ready_before_accept", ready_v[k], 1);
    @(posedge clk);
  endtask

  // mode: 0 plain, 1 hold valid with nd for back-to-back, 2 stray valid pulse,
  //       3 suppress ticks for 100 clk, 4 reset during data bit 3
  task automatic run_frame(input int k, input logic [7:0] d, input int mode, input logic [7:0] nd);
    int ticks, n, os, bad, cyc, limit, supp_at;
    build(k, d);
    os      = os_t[k];
    n       = exp_bits.size() * os;
    ticks   = 0;
    bad     = 0;
    cyc     = 0;
    supp_at = -1;
    limit   = n * 8 + 400;
    while (ticks < n) begin
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin
        check("frame_timeout", cyc, limit);
        valid_v[k] = 1'b0;
        tick_en    = 1'b1;
        return;
      end
      if (ser_v[k] !== exp_bits[ticks / os][0]) bad++;
      if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0 || ready_v[k] !== 1'b0) bad++;
      if (cyc == 1) begin
        if (mode == 1) tx_data = nd;
        else begin
          valid_v[k] = 1'b0;
          tx_data    = 8'($urandom);
        end
      end
      if (mode == 2 && cyc == 20) begin
        tx_data    = 8'h33;
        valid_v[k] = 1'b1;
      end
      if (mode == 2 && cyc == 21) valid_v[k] = 1'b0;
      if (mode == 3 && supp_at < 0 && ticks == 2 * os + 3) begin
        supp_at = cyc;
        tick_en = 1'b0;
      end
      if (mode == 3 && supp_at >= 0 && cyc == supp_at + 100) tick_en = 1'b1;
      if (mode == 4 && ticks == 4 * os + os / 2) begin
        check("pre_reset_bit3", ser_v[k], exp_bits[4]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ser_out", ser_v[k], 1);
        check("rst_busy", busy_v[k], 0);
        check("rst_done", done_v[k], 0);
        check("rst_ready", ready_v[k], 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ready_v[k], 1);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_done", done_v[k], 0);
        check("post_rst_ser", ser_v[k], 1);
        check("frame_bits_before_rst", bad, 0);
        return;
      end
      @(posedge clk);
      if (baud_tick) ticks++;
    end
    @(negedge clk);
    check("frame_bits", bad, 0);
    check("done_pulse", done_v[k], 1);
    check("ready_at_done", ready_v[k], 1);
    check("idle_line_at_done", ser_v[k], 1);
    check("busy_at_done", busy_v[k], 0);
    if (mode == 3) check("suppression_hit", supp_at >= 0, 1);
  endtask

  initial begin
    int k, m;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_all", ready_v, 4'h0);
    check("rst_ser_all", ser_v, 4'hF);
    check("rst_busy_all", busy_v, 4'h0);
    check("rst_done_all", done_v, 4'h0);
    rst = 1'b0;
    #1;
    check("first_ready_all", ready_v, 4'hF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_ticks_ignored", busy_v, 4'h0);

    tick_per = 4;
    accept(0, 8'hA5);
    run_frame(0, 8'hA5, 0, 8'h00);
    accept(1, 8'h07);
    run_frame(1, 8'h07, 0, 8'h00);
    accept(2, 8'h07);
    run_frame(2, 8'h07, 0, 8'h00);

    accept(0, 8'h55);
    run_frame(0, 8'h55, 1, 8'h0F);
    @(posedge clk);
    run_frame(0, 8'h0F, 0, 8'h00);

    accept(0, 8'hFF);
    run_frame(0, 8'hFF, 4, 8'h00);
    accept(0, 8'h81);
    run_frame(0, 8'h81, 0, 8'h00);

    d = 8'($urandom);
    accept(0, d);
    run_frame(0, d, 3, 8'h00);
    d = 8'($urandom);
    accept(0, d);
    run_frame(0, d, 2, 8'h00);

    for (int r = 0; r < 14; r++) begin
      k        = int'($urandom_range(0, 3));
      m        = int'($urandom_range(0, 2));
      tick_per = int'($urandom_range(1, 5));
      d        = 8'($urandom);
      accept(k, d);
      if (m == 1) begin
        logic [7:0] d2;
        d2 = 8'($urandom);
        run_frame(k, d, 1, d2);
        @(posedge clk);
        run_frame(k, d2, 0, 8'h00);
      end else begin
        run_frame(k, d, m, 8'h00);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period; legal range 4..32.
REQ-003 Parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 Port list:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- baud_tick  input  1  one-clk pulse at OVERSAMPLE x bit rate, from the baud generator.
- tx_data  input  DATA_BITS  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  transmitter can accept a byte.
- ser_out  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-clk pulse at end of frame.

Function
REQ-007 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-008 tx_ready SHALL be 1 only in IDLE, when rst = 0.
REQ-009 Handshake: a byte is accepted on a clk edge where tx_valid = 1 and tx_ready = 1; tx_data is latched into a shift register and the FSM moves to START.
REQ-010 tx_valid SHALL be ignored when tx_ready = 0; no byte is queued.
REQ-011 ser_out SHALL be registered; it goes low in the cycle after the acceptance cycle.
REQ-012 On acceptance, the tick counter SHALL clear to 0; a baud_tick in the acceptance cycle is not counted.
REQ-013 Each bit period SHALL last exactly OVERSAMPLE counted baud_ticks; the bit advances on the edge where the tick counter = OVERSAMPLE-1 and baud_tick = 1, and the counter wraps to 0.
REQ-014 Without baud_tick pulses, the FSM, counters and ser_out SHALL hold.
REQ-015 baud_ticks in IDLE SHALL be ignored.
REQ-016 Line levels per state:
- START: 0.
- DATA: LSB first, DATA_BITS bits; a 3-bit bit counter counts 0..DATA_BITS-1.
- PARITY: XOR of the latched data, inverted when PARITY_ODD = 1; entered only when PARITY_EN = 1, otherwise DATA goes directly to STOP.
- STOP: 1 for STOP_BITS bit periods.
REQ-017 Frame length SHALL be (1 + DATA_BITS + PARITY_EN + STOP_BITS) x OVERSAMPLE counted ticks.
REQ-018 On the edge completing the final stop tick: FSM goes to IDLE, tx_done = 1 for exactly that one cycle, and tx_ready = 1 in the same cycle.
REQ-019 Back-to-back: if tx_valid = 1 during the tx_done cycle, the next byte SHALL be accepted then; the next start bit follows with no extra idle bit period.
REQ-020 tx_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-021 Latched data SHALL be unaffected by tx_data changes after acceptance.

Reset
REQ-022 When rst = 1 at a clk edge:
- FSM goes to IDLE.
- ser_out = 1, tx_busy = 0, tx_done = 0, tx_ready = 0 while rst is held.
- Tick counter, bit counter and shift register clear to 0.
REQ-023 Reset mid-frame SHALL abandon the frame: ser_out = 1 in the next cycle, and no tx_done pulse.
REQ-024 tx_ready SHALL be 1 in the first cycle with rst = 0.

Verification
REQ-025 Defaults, baud_tick every 4 clk, send 0xA5 -> ser_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; tx_done pulses once, 640 clk after the start bit begins.
REQ-026 PARITY_EN = 1, PARITY_ODD = 0, send 0x07 -> parity bit 1; with PARITY_ODD = 1 -> parity bit 0; frame = 11 bit periods.
REQ-027 tx_valid held high with 0x55 then 0x0F -> second start bit begins in the cycle after the tx_done cycle; no idle-high gap; both frames correct.
REQ-028 rst asserted during data bit 3 of 0xFF -> ser_out = 1 next cycle, tx_busy = 0, no tx_done; a following 0x81 transmits correctly.
REQ-029 baud_tick suppressed for 100 clk mid-DATA -> ser_out and state frozen; frame resumes with the correct remaining bit lengths.
REQ-030 tx_valid pulsed with 0x33 while tx_busy = 1 -> ignored, and the current frame is unchanged.
